puf_soc_ro_ctrl: RTL and testbench

Measurement sequencer for the ring-oscillator PUF array.
- Per request, takes a challenge naming two ROs, enables only that pair for a programmable window, then lets them settle.
- Samples the two external edge counters, compares them and returns one response bit plus the count difference.
- Sits between the SoC register interface and the RO array / RO counter bank; owns all RO enables so no RO oscillates outside a measurement.

---
 rtl/puf_soc_ro_ctrl.sv | 152 +++++++++++++++
 tb/tb_puf_soc_ro_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/puf_soc_ro_ctrl.sv
// RO-PUF measurement sequencer: enables one RO pair for a window,
// lets the counters settle, then compares them into a response bit.
module puf_soc_ro_ctrl #(
    parameter int NUM_RO       = 16,
    parameter int SEL_W        = 4,
    parameter int CNT_BIT_SIZE = 16,
    parameter int WIN_W        = 12,
    parameter int SETTLE_CYC   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [SEL_W-1:0]        i_chal_a,
    input  logic [SEL_W-1:0]        i_chal_b,
    input  logic [WIN_W-1:0]        i_win_len,
    input  logic [CNT_BIT_SIZE-1:0] i_cnt_a,
    input  logic [CNT_BIT_SIZE-1:0] i_cnt_b,
    output logic [NUM_RO-1:0]       o_ro_en,
    output logic [SEL_W-1:0]        o_sel_a,
    output logic [SEL_W-1:0]        o_sel_b,
    output logic                    o_cnt_clr,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_resp,
    output logic                    o_tie,
    output logic                    o_err,
    output logic [CNT_BIT_SIZE-1:0] o_diff
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [SEL_W:0] LP_NUM = (SEL_W + 1)'(NUM_RO);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DRAIN,
        S_CMP,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [WIN_W-1:0]        r_win_cnt;
    logic [SET_W-1:0]        r_set_cnt;

    logic                    w_valid;
    logic [NUM_RO-1:0]       w_pair;
    logic                    w_gt;
    logic                    w_eq;
    logic [CNT_BIT_SIZE-1:0] w_diff;

    always_comb begin
        w_valid = (i_chal_a != i_chal_b)
               && ({1'b0, i_chal_a} < LP_NUM)
               && ({1'b0, i_chal_b} < LP_NUM)
               && (i_win_len != '0);
        w_pair  = (NUM_RO'(1) << o_sel_a) | (NUM_RO'(1) << o_sel_b);
        w_gt    = (i_cnt_a > i_cnt_b);
        w_eq    = (i_cnt_a == i_cnt_b);
        // Subtract the smaller from the larger so no bit is lost
        w_diff  = w_gt ? (i_cnt_a - i_cnt_b) : (i_cnt_b - i_cnt_a);
    end

    assign o_busy = (r_state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_win_cnt <= '0;
            r_set_cnt <= '0;
            o_ro_en   <= '0;
            o_sel_a   <= '0;
            o_sel_b   <= '0;
            o_cnt_clr <= 1'b0;
            o_done    <= 1'b0;
            o_resp    <= 1'b0;
            o_tie     <= 1'b0;
            o_err     <= 1'b0;
            o_diff    <= '0;
        end else begin
            o_done    <= 1'b0;
            o_cnt_clr <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        o_sel_a   <= i_chal_a;
                        o_sel_b   <= i_chal_b;
                        r_win_cnt <= i_win_len;
                        o_tie     <= 1'b0;
                        o_resp    <= 1'b0;
                        if (w_valid) begin
                            o_err     <= 1'b0;
                            o_cnt_clr <= 1'b1;
                            r_state   <= S_CLR;
                        end else begin
                            o_err   <= 1'b1;
                            o_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_CLR: begin
                    if (i_abort) begin
                        o_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        o_ro_en <= w_pair;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_abort) begin
                        o_ro_en <= '0;
                        o_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_win_cnt == WIN_W'(1)) begin
                        o_ro_en   <= '0;
                        r_set_cnt <= SET_W'(SETTLE_CYC);
                        r_state   <= S_DRAIN;
                    end else begin
                        r_win_cnt <= r_win_cnt - WIN_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (i_abort) begin
                        o_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_set_cnt == SET_W'(1)) begin
                        r_state <= S_CMP;
                    end else begin
                        r_set_cnt <= r_set_cnt - SET_W'(1);
                    end
                end
                S_CMP: begin
                    o_resp  <= w_gt;
                    o_tie   <= w_eq;
                    o_diff  <= w_diff;
                    o_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_soc_ro_ctrl.sv
// Directed bench for puf_soc_ro_ctrl; select width widened to 5 so
// an out-of-range index (16) can be presented with NUM_RO=16.
module tb_puf_soc_ro_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  ca = '0;
    logic [4:0]  cb = '0;
    logic [11:0] win = '0;
    logic [15:0] cnta = '0;
    logic [15:0] cntb = '0;
    logic [15:0] ro_en;
    logic [4:0]  sel_a;
    logic [4:0]  sel_b;
    logic        cnt_clr;
    logic        busy;
    logic        done;
    logic        resp;
    logic        tie;
    logic        err;
    logic [15:0] diff;

    int n_chk = 0;
    int n_fail = 0;
    int en_cyc, mask_bad, clr_cyc, clr_at, done_cnt, done_at;
    logic busy_after;
    logic [15:0] en_after;

    puf_soc_ro_ctrl #(
        .NUM_RO(16), .SEL_W(5), .CNT_BIT_SIZE(16),
        .WIN_W(12), .SETTLE_CYC(4)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_chal_a(ca), .i_chal_b(cb), .i_win_len(win),
        .i_cnt_a(cnta), .i_cnt_b(cntb),
        .o_ro_en(ro_en), .o_sel_a(sel_a), .o_sel_b(sel_b),
        .o_cnt_clr(cnt_clr), .o_busy(busy), .o_done(done),
        .o_resp(resp), .o_tie(tie), .o_err(err), .o_diff(diff)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, then observe ncyc cycles (c = cycles after edge k)
    task automatic run(input logic [4:0] a, input logic [4:0] b,
                       input logic [11:0] w, input logic [15:0] xa,
                       input logic [15:0] xb, input int ab_at,
                       input int bs1, input int bs2, input int bs3,
                       input int ncyc);
        logic [15:0] m;
        m = '0;
        if (a < 16) m = m | (16'h1 << a[3:0]);
        if (b < 16) m = m | (16'h1 << b[3:0]);
        en_cyc = 0; mask_bad = 0; clr_cyc = 0; clr_at = 0;
        done_cnt = 0; done_at = 0; busy_after = 1'bx; en_after = 'x;
        @(negedge clk);
        ca = a; cb = b; win = w; cnta = xa; cntb = xb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (ro_en !== 16'h0) begin
                en_cyc++;
                if (ro_en !== m) mask_bad++;
            end
            if (cnt_clr) begin clr_cyc++; clr_at = c; end
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
            if (c == ab_at + 1) begin busy_after = busy; en_after = ro_en; end
            abort = (c == ab_at);
            if (c == bs1 || c == bs2 || c == bs3) begin
                start = 1'b1; ca = 5'd7; cb = 5'd8;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0; start = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_ro_en", ro_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_clr", cnt_clr, 0);
        chk("rst_outs", {resp, tie, err, diff, sel_a, sel_b}, 0);
        @(negedge clk); rst_n = 1'b1;

        run(5'd3, 5'd9, 12'd100, 16'd1200, 16'd1150, 0, 0, 0, 0, 110);
        chk("basic_en_cyc", en_cyc, 100);
        chk("basic_mask", mask_bad, 0);
        chk("basic_clr_at", clr_at, 1);
        chk("basic_clr_cyc", clr_cyc, 1);
        chk("basic_done_at", done_at, 107);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_res", {resp, tie, err}, 3'b100);
        chk("basic_diff", diff, 50);
        chk("basic_sel", {sel_a, sel_b}, {5'd3, 5'd9});

        run(5'd4, 5'd2, 12'd50, 16'd700, 16'd900, 0, 0, 0, 0, 60);
        chk("rev_done_at", done_at, 57);
        chk("rev_res", {resp, tie, err}, 3'b000);
        chk("rev_diff", diff, 200);

        run(5'd3, 5'd9, 12'd100, 16'd1, 16'd2, 11, 0, 0, 0, 40);
        chk("abort_en_cyc", en_cyc, 10);
        chk("abort_en_next", en_after, 0);
        chk("abort_busy_next", busy_after, 0);
        chk("abort_done_cnt", done_cnt, 0);
        chk("abort_err", err, 1);
        chk("abort_diff_held", diff, 200);

        run(5'd0, 5'd1, 12'd10, 16'd500, 16'd500, 0, 0, 0, 0, 20);
        chk("tie_done_at", done_at, 17);
        chk("tie_res", {resp, tie, err}, 3'b010);
        chk("tie_diff", diff, 0);

        run(5'd5, 5'd5, 12'd10, 16'd9, 16'd1, 0, 0, 0, 0, 5);
        chk("inv_same_done_at", done_at, 1);
        chk("inv_same_quiet", {en_cyc[7:0], clr_cyc[7:0]}, 0);
        chk("inv_same_res", {resp, tie, err}, 3'b001);
        chk("inv_same_done_cnt", done_cnt, 1);

        run(5'd16, 5'd2, 12'd10, 16'd9, 16'd1, 0, 0, 0, 0, 5);
        chk("inv_range_done_at", done_at, 1);
        chk("inv_range_quiet", {en_cyc[7:0], clr_cyc[7:0]}, 0);
        chk("inv_range_err", err, 1);

        run(5'd1, 5'd2, 12'd0, 16'd9, 16'd1, 0, 0, 0, 0, 5);
        chk("inv_win0_done_at", done_at, 1);
        chk("inv_win0_quiet", {en_cyc[7:0], clr_cyc[7:0]}, 0);
        chk("inv_win0_err", err, 1);
        chk("inv_win0_busy", busy, 0);

        run(5'd0, 5'd15, 12'd1, 16'd3, 16'd4, 0, 0, 0, 0, 10);
        chk("w1_en_cyc", en_cyc, 1);
        chk("w1_mask", mask_bad, 0);
        chk("w1_done_at", done_at, 8);
        chk("w1_res", {resp, tie, err, diff}, {3'b000, 16'd1});

        run(5'd14, 5'd13, 12'hFFF, 16'd1000, 16'd10, 0, 0, 0, 0, 4105);
        chk("wmax_en_cyc", en_cyc, 4095);
        chk("wmax_done_at", done_at, 4102);
        chk("wmax_res", {resp, tie, err, diff}, {3'b100, 16'd990});

        @(negedge clk);
        ca = 5'd3; cb = 5'd9; win = 12'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("rstrun_pre_en", ro_en, 16'h0208);
        rst_n = 1'b0;
        #1;
        chk("rstrun_ro_en", ro_en, 0);
        chk("rstrun_outs",
            {busy, done, cnt_clr, resp, tie, err, diff, sel_a, sel_b}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstrun_idle", {busy, ro_en}, 0);

        run(5'd1, 5'd2, 12'd20, 16'hFFFF, 16'h0000, 0, 10, 24, 27, 32);
        chk("busy_sel", {sel_a, sel_b}, {5'd1, 5'd2});
        chk("busy_done_cnt", done_cnt, 1);
        chk("busy_done_at", done_at, 27);
        chk("busy_en_cyc", en_cyc, 20);
        chk("busy_mask", mask_bad, 0);
        chk("busy_idle", busy, 0);
        chk("busy_res", {resp, tie, err, diff}, {3'b100, 16'hFFFF});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
